// File: rtl/note_lane_pkg.sv
// Shared constants and types for the note-lane playfield renderer.
package note_lane_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // green, red, yellow, blue, orange, purple, cyan, pink
    localparam logic [23:0] LANE_COLOUR [0:7] = '{
        24'h00FF00, 24'hFF0000, 24'hFFFF00, 24'h0000FF,
        24'hFF8000, 24'h800080, 24'h00FFFF, 24'hFFC0CB
    };

    typedef struct packed {
        logic       valid;
        logic [9:0] y;
    } slot_t;

endpackage

// File: rtl/note_lane.sv
// One lane of note slots: spawn allocation, per-frame advance, hit judging
// and the "a note covers this row" flag used by the pixel mux.
module note_lane
    import note_lane_pkg::*;
#(
    parameter int SLOTS   = 4,
    parameter int HIT_Y   = 380,
    parameter int HIT_H   = 4,
    parameter int HIT_TOL = 8,
    parameter int NOTE_H  = 16,
    parameter int SPEED   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       spawn,
    input  logic       btn,
    input  logic [9:0] v_count,
    output logic       full,
    output logic       covers,
    output logic       hit,
    output logic       miss
);

    localparam int          IW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [10:0] WIN_LO = 11'(HIT_Y - HIT_TOL);
    localparam logic [10:0] WIN_HI = 11'(HIT_Y + HIT_H + HIT_TOL);

    slot_t         slots [SLOTS];
    logic          btn_q;
    logic          rise_q;
    logic          hit_found;
    logic [IW-1:0] hit_sel;
    logic [IW-1:0] free_sel;

    // Scan high to low so the lowest-index match is the one left standing.
    always_comb begin
        full      = 1'b1;
        covers    = 1'b0;
        hit_found = 1'b0;
        hit_sel   = '0;
        free_sel  = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                full     = 1'b0;
                free_sel = IW'(i);
            end else begin
                if ({1'b0, v_count} >= {1'b0, slots[i].y} &&
                    {1'b0, v_count} < {1'b0, slots[i].y} + 11'(NOTE_H))
                    covers = 1'b1;
                if (rise_q && {1'b0, slots[i].y} < WIN_HI &&
                    {1'b0, slots[i].y} + 11'(NOTE_H) > WIN_LO) begin
                    hit_found = 1'b1;
                    hit_sel   = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q  <= 1'b0;
            rise_q <= 1'b0;
            hit    <= 1'b0;
            miss   <= 1'b0;
            for (int i = 0; i < SLOTS; i++)
                slots[i] <= '0;
        end else begin
            btn_q  <= btn;
            rise_q <= btn & ~btn_q;
            hit    <= hit_found;
            miss   <= 1'b0;
            // A judged note is removed before it can advance or be lost.
            for (int i = 0; i < SLOTS; i++) begin
                if (hit_found && hit_sel == IW'(i)) begin
                    slots[i].valid <= 1'b0;
                end else if (spawn && !full && free_sel == IW'(i)) begin
                    slots[i].valid <= 1'b1;
                    slots[i].y     <= 10'd0;
                end else if (tick && slots[i].valid) begin
                    if ({1'b0, slots[i].y} + 11'(SPEED) >= 11'(V_ACTIVE)) begin
                        slots[i].valid <= 1'b0;
                        miss           <= 1'b1;
                    end else begin
                        slots[i].y <= slots[i].y + 10'(SPEED);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/note_lane_renderer.sv
// Playfield painter: lane geometry decode, hit line, note blocks and the
// spawn handshake, with one registered pixel output.
module note_lane_renderer
    import note_lane_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int SLOTS     = 4,
    parameter int MARGIN    = 4,
    parameter int LANE_W    = 208,
    parameter int GAP_W     = 4,
    parameter int HIT_Y     = 380,
    parameter int HIT_H     = 4,
    parameter int HIT_TOL   = 8,
    parameter int NOTE_H    = 16,
    parameter int SPEED     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           h_count,
    input  logic [9:0]           v_count,
    input  logic                 spawn_valid,
    input  logic [2:0]           spawn_lane,
    output logic                 spawn_ready,
    input  logic [NUM_LANES-1:0] btn,
    output logic [NUM_LANES-1:0] hit_pulse,
    output logic [NUM_LANES-1:0] miss_pulse,
    output logic [23:0]          rgb
);

    logic                 tick;
    logic                 hit_row;
    logic [7:0]           full_pad;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] covers;
    logic [NUM_LANES-1:0] in_lane;
    logic [23:0]          pix;

    assign tick    = (h_count == 10'd0) && (v_count == 10'(V_ACTIVE));
    assign hit_row = (v_count >= 10'(HIT_Y)) && (v_count < 10'(HIT_Y + HIT_H));

    // Lanes that do not exist read as full so they can never be granted.
    always_comb begin
        full_pad                = '1;
        full_pad[NUM_LANES-1:0] = full;
    end

    assign spawn_ready = rst && !tick && ({1'b0, spawn_lane} < 4'(NUM_LANES))
                         && !full_pad[spawn_lane];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam int X0 = MARGIN + k * (LANE_W + GAP_W);

        assign in_lane[k] = ({1'b0, h_count} >= 11'(X0)) &&
                            ({1'b0, h_count} < 11'(X0 + LANE_W));

        note_lane #(
            .SLOTS   (SLOTS),
            .HIT_Y   (HIT_Y),
            .HIT_H   (HIT_H),
            .HIT_TOL (HIT_TOL),
            .NOTE_H  (NOTE_H),
            .SPEED   (SPEED)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .spawn   (spawn_valid && spawn_ready && (spawn_lane == 3'(k))),
            .btn     (btn[k]),
            .v_count (v_count),
            .full    (full[k]),
            .covers  (covers[k]),
            .hit     (hit_pulse[k]),
            .miss    (miss_pulse[k])
        );
    end

    // Lanes are disjoint in x, so at most one branch below takes effect.
    always_comb begin
        pix = 24'h000000;
        if (h_count < 10'(H_ACTIVE) && v_count < 10'(V_ACTIVE) && !hit_row) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (in_lane[k])
                    pix = covers[k] ? LANE_COLOUR[k] : 24'hFFFFFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            rgb <= 24'h000000;
        else
            rgb <= pix;
    end

endmodule
